// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite self-test master: writes NUM_VEC arithmetic-progression words,
// reads each back, and counts response and data errors.
//
// Ports:
//   ACLK, ARESETN         clock, synchronous active-low reset
//   start                 one-cycle pulse that begins a run (ignored while busy)
//   busy, done, pass      run status; pass is valid at done and held
//   err_count[8:0]        saturating error count for the current run
//   M_AXI_AW*/W*/B*       write channels (master side)
//   M_AXI_AR*/R*          read channels (master side)
module axi_lite_selftest_master #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_VEC     = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]           SEED        = 32'h0101FFFF,
    parameter logic [31:0]           INCR        = 32'h11111111,
    parameter bit                    STOP_ON_ERR = 1'b0,
    parameter int                    TIMEOUT     = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [8:0]                err_count,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam logic [DATA_WIDTH-1:0] SEED_X = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] INCR_X = DATA_WIDTH'(INCR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [8:0]            LAST   = 9'(NUM_VEC - 1);
    localparam logic [31:0]           WMAX   = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_NEXT, S_FIN
    } state_t;

    state_t                state;
    logic [8:0]            idx;
    logic [31:0]           wait_cnt;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    // A channel is finished once its VALID has dropped or it handshakes now.
    logic aw_ok;
    logic w_ok;
    assign aw_ok = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_ok  = !M_AXI_WVALID  || M_AXI_WREADY;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = exp_q;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= S_IDLE;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            idx           <= '0;
            wait_cnt      <= '0;
            exp_q         <= SEED_X;
            addr_q        <= BASE_ADDR;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        idx           <= '0;
                        exp_q         <= SEED_X;
                        addr_q        <= BASE_ADDR;
                        wait_cnt      <= '0;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= S_WR;
                    end
                end
                S_WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        M_AXI_BREADY <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= S_WRESP;
                    end else if (wait_cnt == WMAX) begin
                        err_count     <= sat_inc(err_count);
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b0;
                        state         <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_WRESP: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00)
                            err_count <= sat_inc(err_count);
                        M_AXI_BREADY  <= 1'b0;
                        M_AXI_ARVALID <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= S_RD;
                    end else if (wait_cnt == WMAX) begin
                        err_count    <= sat_inc(err_count);
                        M_AXI_BREADY <= 1'b0;
                        state        <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RD: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= S_RDATA;
                    end else if (wait_cnt == WMAX) begin
                        err_count     <= sat_inc(err_count);
                        M_AXI_ARVALID <= 1'b0;
                        state         <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RDATA: begin
                    if (M_AXI_RVALID) begin
                        if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != exp_q)
                            err_count <= sat_inc(err_count);
                        M_AXI_RREADY <= 1'b0;
                        wait_cnt     <= '0;
                        state        <= S_NEXT;
                    end else if (wait_cnt == WMAX) begin
                        err_count    <= sat_inc(err_count);
                        M_AXI_RREADY <= 1'b0;
                        state        <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_NEXT: begin
                    idx      <= idx + 9'd1;
                    exp_q    <= exp_q + INCR_X;
                    addr_q   <= addr_q + STRIDE;
                    wait_cnt <= '0;
                    if (idx == LAST || (STOP_ON_ERR && err_count != 9'd0)) begin
                        state <= S_FIN;
                    end else begin
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= S_WR;
                    end
                end
                S_FIN: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    pass     <= (err_count == 9'd0);
                    wait_cnt <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Bench for axi_lite_selftest_master: two DUTs (stop-on-error off / on with
// short timeout), each driven by a configurable RAM slave.
module tb_axi_lite_selftest_master;

    localparam logic [31:0] SEED = 32'h0101FFFF;
    localparam logic [31:0] INCR = 32'h11111111;

    logic tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    logic        start   [2];
    logic        rstn    [2];
    logic        clr     [2];
    wire         busy    [2];
    wire         done    [2];
    wire         pass    [2];
    wire  [8:0]  err_cnt [2];
    wire  [31:0] awaddr  [2];
    wire  [2:0]  awprot  [2];
    wire         awvalid [2];
    wire         awready [2];
    wire  [31:0] wdata   [2];
    wire  [3:0]  wstrb   [2];
    wire         wvalid  [2];
    wire         wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    wire         bready  [2];
    wire  [31:0] araddr  [2];
    wire  [2:0]  arprot  [2];
    wire         arvalid [2];
    wire         arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    wire         rready  [2];

    int aw_dly [2];
    int w_dly  [2];
    int ar_dly [2];
    int ar_never [2];
    int corrupt_vec [2];
    int bresp_err_vec [2];

    int aw_cnt [2];
    int w_cnt  [2];
    int ar_cnt [2];
    logic aw_got [2];
    logic w_got  [2];
    logic [31:0] aw_lat [2];
    logic [31:0] w_lat  [2];
    logic [31:0] mem [2][256];
    logic [31:0] wlog_addr [2][16];
    logic [31:0] wlog_data [2][16];
    logic [31:0] rlog_addr [2][16];
    int wr_count [2];
    int rd_count [2];
    int aw_hs [2];
    int w_hs  [2];
    int arv_cyc [2];

    int checks = 0;
    int errors = 0;

    for (genvar k = 0; k < 2; k++) begin : g
        axi_lite_selftest_master #(
            .STOP_ON_ERR (k == 1 ? 1'b1 : 1'b0),
            .TIMEOUT     (k == 1 ? 16 : 1024)
        ) dut (
            .ACLK          (tb_ACLK),
            .ARESETN       (rstn[k]),
            .start         (start[k]),
            .busy          (busy[k]),
            .done          (done[k]),
            .pass          (pass[k]),
            .err_count     (err_cnt[k]),
            .M_AXI_AWADDR  (awaddr[k]),
            .M_AXI_AWPROT  (awprot[k]),
            .M_AXI_AWVALID (awvalid[k]),
            .M_AXI_AWREADY (awready[k]),
            .M_AXI_WDATA   (wdata[k]),
            .M_AXI_WSTRB   (wstrb[k]),
            .M_AXI_WVALID  (wvalid[k]),
            .M_AXI_WREADY  (wready[k]),
            .M_AXI_BRESP   (bresp[k]),
            .M_AXI_BVALID  (bvalid[k]),
            .M_AXI_BREADY  (bready[k]),
            .M_AXI_ARADDR  (araddr[k]),
            .M_AXI_ARPROT  (arprot[k]),
            .M_AXI_ARVALID (arvalid[k]),
            .M_AXI_ARREADY (arready[k]),
            .M_AXI_RDATA   (rdata[k]),
            .M_AXI_RRESP   (rresp[k]),
            .M_AXI_RVALID  (rvalid[k]),
            .M_AXI_RREADY  (rready[k])
        );

        assign awready[k] = awvalid[k] && (aw_cnt[k] >= aw_dly[k]);
        assign wready[k]  = wvalid[k] && (w_cnt[k] >= w_dly[k]);
        assign arready[k] = arvalid[k] && (ar_never[k] == 0)
                            && (ar_cnt[k] >= ar_dly[k]);

        always @(posedge tb_ACLK) begin
            if (clr[k]) begin
                aw_cnt[k]   <= 0;
                w_cnt[k]    <= 0;
                ar_cnt[k]   <= 0;
                aw_got[k]   <= 1'b0;
                w_got[k]    <= 1'b0;
                bvalid[k]   <= 1'b0;
                bresp[k]    <= 2'b00;
                rvalid[k]   <= 1'b0;
                rresp[k]    <= 2'b00;
                rdata[k]    <= '0;
                wr_count[k] <= 0;
                rd_count[k] <= 0;
                aw_hs[k]    <= 0;
                w_hs[k]     <= 0;
                arv_cyc[k]  <= 0;
            end else begin
                if (awvalid[k]) begin
                    if (awready[k]) begin
                        aw_cnt[k] <= 0;
                        aw_got[k] <= 1'b1;
                        aw_lat[k] <= awaddr[k];
                        aw_hs[k]  <= aw_hs[k] + 1;
                    end else begin
                        aw_cnt[k] <= aw_cnt[k] + 1;
                    end
                end
                if (wvalid[k]) begin
                    if (wready[k]) begin
                        w_cnt[k] <= 0;
                        w_got[k] <= 1'b1;
                        w_lat[k] <= wdata[k];
                        w_hs[k]  <= w_hs[k] + 1;
                    end else begin
                        w_cnt[k] <= w_cnt[k] + 1;
                    end
                end
                if (aw_got[k] && w_got[k]) begin
                    mem[k][aw_lat[k][9:2]] <= w_lat[k];
                    wlog_addr[k][wr_count[k] % 16] <= aw_lat[k];
                    wlog_data[k][wr_count[k] % 16] <= w_lat[k];
                    wr_count[k] <= wr_count[k] + 1;
                    bresp[k] <= (wr_count[k] == bresp_err_vec[k])
                                ? 2'b10 : 2'b00;
                    bvalid[k] <= 1'b1;
                    aw_got[k] <= 1'b0;
                    w_got[k]  <= 1'b0;
                end
                if (bvalid[k] && bready[k])
                    bvalid[k] <= 1'b0;
                if (arvalid[k]) begin
                    arv_cyc[k] <= arv_cyc[k] + 1;
                    if (arready[k]) begin
                        ar_cnt[k] <= 0;
                        rdata[k]  <= mem[k][araddr[k][9:2]]
                                     ^ ((rd_count[k] == corrupt_vec[k])
                                        ? 32'h1 : 32'h0);
                        rresp[k]  <= 2'b00;
                        rvalid[k] <= 1'b1;
                        rlog_addr[k][rd_count[k] % 16] <= araddr[k];
                        rd_count[k] <= rd_count[k] + 1;
                    end else begin
                        ar_cnt[k] <= ar_cnt[k] + 1;
                    end
                end
                if (rvalid[k] && rready[k])
                    rvalid[k] <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] vec_data(input int i);
        return SEED + 32'(i) * INCR;
    endfunction

    function automatic logic [31:0] vec_addr(input int i);
        return 32'(i * 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic knobs(input int k, input int a, input int w, input int r);
        aw_dly[k]        = a;
        w_dly[k]         = w;
        ar_dly[k]        = r;
        ar_never[k]      = 0;
        corrupt_vec[k]   = -1;
        bresp_err_vec[k] = -1;
    endtask

    task automatic clear(input int k);
        @(negedge tb_ACLK);
        clr[k] = 1'b1;
        @(negedge tb_ACLK);
        clr[k] = 1'b0;
    endtask

    task automatic pulse_start(input int k);
        @(negedge tb_ACLK);
        start[k] = 1'b1;
        @(negedge tb_ACLK);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge tb_ACLK);
            if (done[k]) seen = 1'b1;
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
    endtask

    task automatic run(input int k, input string tag);
        clear(k);
        pulse_start(k);
        wait_done(k, tag);
    endtask

    task automatic check_writes(input int k, input int n, input string tag);
        check({tag, "_wr_count"}, 64'(wr_count[k]), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_wa%0d", tag, i),
                  64'(wlog_addr[k][i]), 64'(vec_addr(i)));
            check($sformatf("%s_wd%0d", tag, i),
                  64'(wlog_data[k][i]), 64'(vec_data(i)));
        end
    endtask

    task automatic check_result(input int k, input int e, input string tag);
        check({tag, "_err"}, 64'(err_cnt[k]), 64'(e));
        check({tag, "_pass"}, 64'(pass[k]), 64'(e == 0));
        check({tag, "_busy"}, 64'(busy[k]), 64'd0);
    endtask

    initial begin
        int c;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            rstn[k]  = 1'b0;
            clr[k]   = 1'b1;
            knobs(k, 0, 0, 0);
        end
        repeat (3) @(negedge tb_ACLK);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_outs%0d", k),
                  64'({awvalid[k], wvalid[k], bready[k], arvalid[k],
                       rready[k], busy[k], done[k], pass[k], err_cnt[k]}),
                  64'd0);
            rstn[k] = 1'b1;
            clr[k]  = 1'b0;
        end

        // zero-wait ideal RAM
        knobs(0, 0, 0, 0);
        clear(0);
        pulse_start(0);
        check("ideal_busy", 64'(busy[0]), 64'd1);
        check("ideal_prot_strb", 64'({awprot[0], arprot[0], wstrb[0]}),
              64'h00F);
        wait_done(0, "ideal");
        check_result(0, 0, "ideal");
        check_writes(0, 4, "ideal");
        check("ideal_rd_count", 64'(rd_count[0]), 64'd4);
        @(negedge tb_ACLK);
        check("ideal_done_pulse", 64'(done[0]), 64'd0);
        repeat (3) @(negedge tb_ACLK);
        check("ideal_pass_held", 64'(pass[0]), 64'd1);

        // skewed AW/W acceptance, both directions
        knobs(0, 3, 0, 0);
        run(0, "aw_late");
        check_result(0, 0, "aw_late");
        check("aw_late_hs", 64'({16'(aw_hs[0]), 16'(w_hs[0])}), 64'h00040004);
        check_writes(0, 4, "aw_late");
        knobs(0, 0, 3, 0);
        run(0, "w_late");
        check_result(0, 0, "w_late");
        check("w_late_hs", 64'({16'(aw_hs[0]), 16'(w_hs[0])}), 64'h00040004);

        // random delays; a second start mid-run must be ignored
        for (int r = 0; r < 4; r++) begin
            knobs(r % 2, $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4));
            clear(r % 2);
            pulse_start(r % 2);
            repeat ($urandom_range(1, 6)) @(negedge tb_ACLK);
            start[r % 2] = 1'b1;
            @(negedge tb_ACLK);
            start[r % 2] = 1'b0;
            wait_done(r % 2, $sformatf("rand%0d", r));
            check_result(r % 2, 0, $sformatf("rand%0d", r));
            check_writes(r % 2, 4, $sformatf("rand%0d", r));
            check($sformatf("rand%0d_aw_hs", r), 64'(aw_hs[r % 2]), 64'd4);
        end

        // corrupted read of vector 2, no stop
        knobs(0, 0, 0, 0);
        corrupt_vec[0] = 2;
        run(0, "corrupt");
        check_result(0, 1, "corrupt");
        check("corrupt_rd_count", 64'(rd_count[0]), 64'd4);
        check_writes(0, 4, "corrupt");

        // corrupted read with stop-on-error
        knobs(1, 0, 0, 0);
        corrupt_vec[1] = 2;
        run(1, "stop");
        check_result(1, 1, "stop");
        check_writes(1, 3, "stop");

        // random corrupted vector with stop-on-error
        c = $urandom_range(0, 3);
        knobs(1, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        corrupt_vec[1] = c;
        run(1, "stop_rand");
        check_result(1, 1, "stop_rand");
        check("stop_rand_wr", 64'(wr_count[1]), 64'(c + 1));

        // SLVERR on write of vector 1
        knobs(0, 0, 0, 0);
        bresp_err_vec[0] = 1;
        run(0, "slverr");
        check_result(0, 1, "slverr");
        check("slverr_rd_count", 64'(rd_count[0]), 64'd4);
        check("slverr_rd1_addr", 64'(rlog_addr[0][1]), 64'(vec_addr(1)));

        // read address never accepted, timeout 16
        knobs(1, 0, 0, 0);
        ar_never[1] = 1;
        run(1, "artmo");
        check_result(1, 1, "artmo");
        check("artmo_arv_cycles", 64'(arv_cyc[1]), 64'd16);
        check("artmo_arvalid", 64'(arvalid[1]), 64'd0);
        check("artmo_wr", 64'(wr_count[1]), 64'd1);
        check("artmo_rd", 64'(rd_count[1]), 64'd0);

        // reset in the middle of a write
        knobs(0, 5, 5, 0);
        clear(0);
        pulse_start(0);
        check("midrst_in_wr", 64'({awvalid[0], wvalid[0]}), 64'd3);
        rstn[0] = 1'b0;
        @(posedge tb_ACLK);
        #1;
        check("midrst_outs",
              64'({awvalid[0], wvalid[0], bready[0], arvalid[0],
                   rready[0], busy[0], done[0], pass[0], err_cnt[0]}),
              64'd0);
        @(negedge tb_ACLK);
        rstn[0] = 1'b1;
        knobs(0, 0, 0, 0);
        run(0, "after_rst");
        check_result(0, 0, "after_rst");
        check_writes(0, 4, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
